// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter for a single shared memory port, one transaction in flight.
// Optional ARB_RR_EN enables round-robin on conflicts; otherwise the LSU always wins.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        gnt_lsu_q, gnt_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ifu_resp_q, ifu_resp_d;
  logic        lsu_resp_q, lsu_resp_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        err_q, err_d;

  logic        lsu_wins;
  logic        idle;
  logic        accept;

`ifdef ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  // On a conflict the master that was not granted last takes the port.
  assign lsu_wins = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (accept) begin
      last_lsu_d = lsu_wins;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  assign lsu_wins = lsu_req_valid;
`endif

  // Readys are gated by reset so every output reads 0 while rst_n is low.
  assign idle          = (state_q == StIdle) & rst_n;
  assign lsu_req_ready = idle & lsu_wins;
  assign ifu_req_ready = idle & ifu_req_valid & ~lsu_wins;
  assign accept        = ifu_req_ready | lsu_req_ready;

  always_comb begin
    state_d     = state_q;
    gnt_lsu_d   = gnt_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    ifu_rdata_d = '0;
    lsu_rdata_d = '0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          gnt_lsu_d = lsu_wins;
          addr_d    = lsu_wins ? lsu_addr : ifu_addr;
          wen_d     = lsu_wins & lsu_wen;
          wdata_d   = lsu_wins ? lsu_wdata : '0;
          wmask_d   = lsu_wins ? lsu_wmask : 8'h00;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response in the final timeout cycle still delivers real data.
        if (mem_resp_valid) begin
          ifu_resp_d  = ~gnt_lsu_q;
          lsu_resp_d  = gnt_lsu_q;
          ifu_rdata_d = gnt_lsu_q ? '0 : mem_rdata;
          lsu_rdata_d = gnt_lsu_q ? mem_rdata : '0;
          state_d     = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          ifu_resp_d = ~gnt_lsu_q;
          lsu_resp_d = gnt_lsu_q;
          err_d      = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_lsu_q   <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_lsu_q   <= gnt_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_valid  = (state_q == StReq);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign resp_err       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..255: number of WAIT cycles without a memory response before a timeout is forced.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ifu_req_valid  input  1  instruction fetch read request.
REQ-005 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-006 ifu_addr  input  32  IFU read address.
REQ-007 ifu_resp_valid  output  1  one-cycle pulse; IFU response data valid.
REQ-008 ifu_rdata  output  32  IFU read data.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-011 lsu_addr  input  32  LSU address.
REQ-012 lsu_wen  input  1  1 = store, 0 = load.
REQ-013 lsu_wdata  input  32  store data.
REQ-014 lsu_wmask  input  8  byte mask; only bits [3:0] are meaningful.
REQ-015 lsu_resp_valid  output  1  one-cycle pulse; LSU response valid (load data, or store done).
REQ-016 lsu_rdata  output  32  LSU load data.
REQ-017 mem_req_valid  output  1  request to the shared memory port.
REQ-018 mem_req_ready  input  1  memory accepts the request.
REQ-019 mem_addr  output  32  memory address.
REQ-020 mem_wen  output  1  memory write enable.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_wmask  output  8  memory byte mask.
REQ-023 mem_resp_valid  input  1  memory response pulse.
REQ-024 mem_rdata  input  32  memory read data.
REQ-025 resp_err  output  1  timeout flag, qualified by ifu_resp_valid or lsu_resp_valid.

Function
REQ-026 The FSM SHALL have three states:
- IDLE: accept one request.
- REQ: drive the memory port.
- WAIT: await the response.
At most one transaction is outstanding.
REQ-027 Request ready and acceptance:
- In IDLE, the arbitration winner's req_ready SHALL be driven high combinationally; the other master's ready stays low.
- In REQ and WAIT, both readys SHALL be low.
- When valid & ready, latch the master id, address, wen, wdata and wmask, then go to REQ.
- An IFU request SHALL be latched with wen=0 and wmask=8'h00.
REQ-028 In REQ, mem_req_valid=1 and the latched fields SHALL be held stable until mem_req_ready; then go to WAIT and clear the timeout counter.
REQ-029 In WAIT, on mem_resp_valid the granted master's resp_valid SHALL pulse on the next cycle (registered), with rdata = captured mem_rdata and resp_err=0; the FSM returns to IDLE on the same edge.
REQ-030 Timeout:
- The 8-bit counter SHALL increment on each WAIT cycle without mem_resp_valid.
- In the TIMEOUT-th such consecutive cycle, return the same registered pulse with rdata=0 and resp_err=1, then go to IDLE.
REQ-031 If mem_resp_valid coincides with the timeout cycle, the response SHALL win (resp_err=0, real data).
REQ-032 mem_resp_valid in IDLE or REQ SHALL be ignored.
REQ-033 Minimum latency from acceptance (cycle N) to master resp_valid, with mem_req_ready=1 at N+1 and mem_resp_valid at N+2, SHALL be cycle N+3.
REQ-034 IDLE SHALL be able to accept a new request in the same cycle the previous resp_valid pulses.
REQ-035 resp_valid SHALL never pulse to both masters in one cycle; rdata and resp_err SHALL be 0 whenever no resp_valid is high.

Reset
REQ-036 When rst_n=0, the block SHALL immediately go to IDLE, with the counter and all outputs 0 and the round-robin pointer = IFU-last. Any in-flight transaction SHALL be dropped with no response.
REQ-037 The block SHALL leave reset on the first rising clk edge with rst_n=1.

Configuration
REQ-038 With ARB_RR_EN defined, arbitration SHALL be round-robin: on a conflict the master not granted last wins, and the pointer updates on every acceptance. The reset pointer gives the LSU the first conflict.
REQ-039 Without ARB_RR_EN, the LSU SHALL always win conflicts, and no pointer register SHALL exist.

Verification
REQ-040 IFU read:
- Stimulus: IFU only, addr 0x80000000; mem ready at once; resp next cycle with 0x00000413.
- Required: ifu_resp_valid one cycle at N+3, ifu_rdata 0x00000413, resp_err 0, lsu_resp_valid 0.
REQ-041 Conflict:
- Stimulus: both masters held valid continuously.
- Required with ARB_RR_EN: grants L,I,L,I.
- Required without ARB_RR_EN: L,L,L,L (IFU never granted).
REQ-042 Store:
- Stimulus: LSU store, addr 0x80001002, wdata 0xDEADBEEF, wmask 0x0C.
- Required: mem_wen=1 and mem_addr/wdata/wmask match exactly; mem_req_ready held low 3 cycles leaves the fields stable; lsu_resp_valid after mem_resp_valid.
REQ-043 Timeout:
- Stimulus: TIMEOUT=4, no mem_resp_valid.
- Required: resp pulse with resp_err=1, rdata 0 on the cycle after the 4th WAIT cycle; the next request is accepted.
REQ-044 Response/timeout collision:
- Stimulus: TIMEOUT=4, mem_resp_valid with 0x12345678 in the 4th WAIT cycle.
- Required: resp_err=0, rdata 0x12345678.
REQ-045 Reset mid-transaction:
- Stimulus: rst_n low in WAIT, then release; a stray mem_resp_valid arrives afterwards.
- Required: outputs 0 asynchronously; no resp_valid produced.
